i2c_slave_rx_sequencer: RTL and testbench

Sequencing controller for the I2C slave receive path. It drives the byte-read and ACK-write engines through a write transaction: address byte, address compare, address ACK, then repeated data byte/ACK pairs. Received data goes to the host through a one-entry valid/ready buffer. It sits between the bus-condition detector (START/STOP pulses) and the slave register or FIFO logic. Read-direction (slave-transmit) transactions are only flagged here and handed off.

---
 rtl/i2c_slave_rx_sequencer_if.sv | 43 ++++
 rtl/i2c_slave_rx_sequencer.sv | 166 ++++++++++++++++
 tb/tb_i2c_slave_rx_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_rx_sequencer_if.sv
// Signal bundle between the I2C slave receive sequencer and its bus-condition detector, bit engines and host.
// The slave modport is the sequencer's view; master is the view of the surrounding logic.
interface i2c_slave_rx_sequencer_if;
  logic       start_det;
  logic       stop_det;
  logic       byte_read_en;
  logic [7:0] byte_read_i;
  logic       byte_read_finish_i;
  logic       byte_read_err_i;
  logic       ack_write_en;
  logic       ack_value;
  logic       ack_write_finish_i;
  logic       ack_write_err_i;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       addr_match;
  logic       tx_req;
  logic       busy;
  logic [7:0] rx_count;
  logic       overrun;
  logic       err;

  modport slave (
    input  start_det, stop_det,
    input  byte_read_i, byte_read_finish_i, byte_read_err_i,
    input  ack_write_finish_i, ack_write_err_i,
    input  rx_ready,
    output byte_read_en, ack_write_en, ack_value,
    output rx_data, rx_valid,
    output addr_match, tx_req, busy, rx_count, overrun, err
  );

  modport master (
    output start_det, stop_det,
    output byte_read_i, byte_read_finish_i, byte_read_err_i,
    output ack_write_finish_i, ack_write_err_i,
    output rx_ready,
    input  byte_read_en, ack_write_en, ack_value,
    input  rx_data, rx_valid,
    input  addr_match, tx_req, busy, rx_count, overrun, err
  );
endinterface

// File: rtl/i2c_slave_rx_sequencer.sv
// I2C slave write-path sequencer: address, ACK, data/ACK loop into a one-entry rx buffer.
// All outputs registered (1 cycle after the event); a full buffer NACKs the incoming byte.
module i2c_slave_rx_sequencer #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic                          clk,
  input  logic                          rst_n,
  i2c_slave_rx_sequencer_if.slave       bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    HANDOFF,
    WAIT_STOP
  } state_t;

  state_t     state_q, state_d;
  logic       byte_read_en_q;
  logic       ack_write_en_q;
  logic       ack_value_q, ack_value_d;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       addr_match_q, addr_match_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q;
  logic [7:0] rx_count_q, rx_count_d;
  logic       overrun_q, overrun_d;
  logic       err_q, err_d;
  logic       load;
  logic       accept;
  logic       buf_free;
  logic       engine_err;

  assign accept   = rx_valid_q && bus.rx_ready;
  assign buf_free = !rx_valid_q || bus.rx_ready;

  assign engine_err = (bus.byte_read_err_i && (state_q == ADDR || state_q == DATA)) ||
                      (bus.ack_write_err_i && (state_q == ADDR_ACK || state_q == DATA_ACK));

  // Bus conditions outrank engine errors, which outrank normal sequencing.
  always_comb begin
    state_d      = state_q;
    ack_value_d  = ack_value_q;
    addr_match_d = addr_match_q;
    rx_count_d   = rx_count_q;
    tx_req_d     = 1'b0;
    overrun_d    = 1'b0;
    err_d        = 1'b0;
    load         = 1'b0;

    if (bus.stop_det) begin
      state_d      = IDLE;
      addr_match_d = 1'b0;
    end else if (bus.start_det) begin
      state_d      = ADDR;
      addr_match_d = 1'b0;
      rx_count_d   = 8'd0;
    end else if (engine_err) begin
      state_d = WAIT_STOP;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (bus.byte_read_finish_i) begin
            if (bus.byte_read_i[7:1] == SLAVE_ADDR) begin
              addr_match_d = 1'b1;
              if (bus.byte_read_i[0]) begin
                tx_req_d = 1'b1;
                state_d  = HANDOFF;
              end else begin
                ack_value_d = 1'b0;
                state_d     = ADDR_ACK;
              end
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (bus.ack_write_finish_i) begin
            state_d = ack_value_q ? WAIT_STOP : DATA;
          end
        end
        DATA: begin
          if (bus.byte_read_finish_i) begin
            state_d = DATA_ACK;
            if (buf_free) begin
              load        = 1'b1;
              ack_value_d = 1'b0;
              rx_count_d  = rx_count_q + 8'd1;
            end else begin
              ack_value_d = 1'b1;
              overrun_d   = 1'b1;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // Outside an ACK slot the line is released.
    if (state_d != ADDR_ACK && state_d != DATA_ACK) begin
      ack_value_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      byte_read_en_q <= 1'b0;
      ack_write_en_q <= 1'b0;
      ack_value_q    <= 1'b1;
      addr_match_q   <= 1'b0;
      tx_req_q       <= 1'b0;
      busy_q         <= 1'b0;
      rx_count_q     <= 8'd0;
      overrun_q      <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_read_en_q <= (state_d == ADDR) || (state_d == DATA);
      ack_write_en_q <= (state_d == ADDR_ACK) || (state_d == DATA_ACK);
      ack_value_q    <= ack_value_d;
      addr_match_q   <= addr_match_d;
      tx_req_q       <= tx_req_d;
      busy_q         <= (state_d != IDLE);
      rx_count_q     <= rx_count_d;
      overrun_q      <= overrun_d;
      err_q          <= err_d;
    end
  end

  // The rx buffer runs on its own so the host can drain it after STOP/START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      if (load) begin
        rx_data_q  <= bus.byte_read_i;
        rx_valid_q <= 1'b1;
      end else if (accept) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.byte_read_en = byte_read_en_q;
  assign bus.ack_write_en = ack_write_en_q;
  assign bus.ack_value    = ack_value_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.addr_match   = addr_match_q;
  assign bus.tx_req       = tx_req_q;
  assign bus.busy         = busy_q;
  assign bus.rx_count     = rx_count_q;
  assign bus.overrun      = overrun_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_i2c_slave_rx_sequencer.sv
// Bench for i2c_slave_rx_sequencer: directed transactions, a transaction-level reference
// model compared every cycle, and hand-computed checkpoints.
module tb_i2c_slave_rx_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  i2c_slave_rx_sequencer_if bus ();

  i2c_slave_rx_sequencer #(.SLAVE_ADDR(7'h50)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bus phase of the transaction plus the observable registers.
  localparam logic [2:0] P_IDLE = 3'd0, P_ADDR = 3'd1, P_AACK = 3'd2, P_DATA = 3'd3,
                         P_DACK = 3'd4, P_HAND = 3'd5, P_WAIT = 3'd6;

  typedef struct packed {
    logic [2:0] ph;
    logic       ack;
    logic       match;
    logic [7:0] cnt;
    logic       rxv;
    logic [7:0] rxd;
    logic       tx;
    logic       ovr;
    logic       err;
  } mst_t;

  mst_t m;

  function automatic mst_t reset_model();
    mst_t r;
    r = '0;
    r.ph  = P_IDLE;
    r.ack = 1'b1;
    return r;
  endfunction

  function automatic mst_t step(mst_t s);
    mst_t n;
    logic free;
    logic ld;
    logic in_ack;
    n      = s;
    n.tx   = 1'b0;
    n.ovr  = 1'b0;
    n.err  = 1'b0;
    ld     = 1'b0;
    free   = !s.rxv || bus.rx_ready;
    in_ack = (s.ph == P_AACK) || (s.ph == P_DACK);
    if (bus.stop_det) begin
      n.ph = P_IDLE; n.match = 1'b0;
    end else if (bus.start_det) begin
      n.ph = P_ADDR; n.match = 1'b0; n.cnt = 8'd0;
    end else if ((bus.byte_read_err_i && (s.ph == P_ADDR || s.ph == P_DATA)) ||
                 (bus.ack_write_err_i && in_ack)) begin
      n.ph = P_WAIT; n.err = 1'b1;
    end else if (s.ph == P_ADDR && bus.byte_read_finish_i) begin
      if (bus.byte_read_i[7:1] == 7'h50) begin
        n.match = 1'b1;
        if (bus.byte_read_i[0]) begin
          n.tx = 1'b1; n.ph = P_HAND;
        end else begin
          n.ack = 1'b0; n.ph = P_AACK;
        end
      end else begin
        n.ph = P_WAIT;
      end
    end else if (in_ack && bus.ack_write_finish_i) begin
      n.ph = s.ack ? P_WAIT : P_DATA;
    end else if (s.ph == P_DATA && bus.byte_read_finish_i) begin
      n.ph = P_DACK;
      if (free) begin
        ld = 1'b1; n.ack = 1'b0; n.cnt = s.cnt + 8'd1;
      end else begin
        n.ack = 1'b1; n.ovr = 1'b1;
      end
    end
    if (ld) begin
      n.rxv = 1'b1; n.rxd = bus.byte_read_i;
    end else if (s.rxv && bus.rx_ready) begin
      n.rxv = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= reset_model();
    else        m <= step(m);
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%02h expected 0x%02h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk1("cyc_byte_read_en", bus.byte_read_en, m.ph == P_ADDR || m.ph == P_DATA);
    chk1("cyc_ack_write_en", bus.ack_write_en, m.ph == P_AACK || m.ph == P_DACK);
    if (m.ph == P_AACK || m.ph == P_DACK) chk1("cyc_ack_value", bus.ack_value, m.ack);
    chk1("cyc_busy", bus.busy, m.ph != P_IDLE);
    chk1("cyc_addr_match", bus.addr_match, m.match);
    chk1("cyc_tx_req", bus.tx_req, m.tx);
    chk1("cyc_overrun", bus.overrun, m.ovr);
    chk1("cyc_err", bus.err, m.err);
    chk8("cyc_rx_count", bus.rx_count, m.cnt);
    chk1("cyc_rx_valid", bus.rx_valid, m.rxv);
    if (m.rxv) chk8("cyc_rx_data", bus.rx_data, m.rxd);
  end

  // Bytes actually handed to the host.
  logic [7:0] got[$];
  always @(negedge clk) begin
    if (rst_n && bus.rx_valid && bus.rx_ready) got.push_back(bus.rx_data);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_start();
    bus.start_det = 1'b1; tick(); bus.start_det = 1'b0;
  endtask

  task automatic send_stop();
    bus.stop_det = 1'b1; tick(); bus.stop_det = 1'b0; tick();
  endtask

  task automatic rd_byte(input logic [7:0] b);
    tick();
    bus.byte_read_i = b; bus.byte_read_finish_i = 1'b1; tick();
    bus.byte_read_finish_i = 1'b0;
  endtask

  task automatic ack_slot(input string name, input logic exp_ack);
    chk1({name, "_ack_en"}, bus.ack_write_en, 1'b1);
    chk1({name, "_ack_value"}, bus.ack_value, exp_ack);
    tick();
    bus.ack_write_finish_i = 1'b1; tick(); bus.ack_write_finish_i = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    chk1({name, "_byte_read_en"}, bus.byte_read_en, 1'b0);
    chk1({name, "_ack_write_en"}, bus.ack_write_en, 1'b0);
    chk1({name, "_ack_value"}, bus.ack_value, 1'b1);
    chk8({name, "_rx_data"}, bus.rx_data, 8'h00);
    chk1({name, "_rx_valid"}, bus.rx_valid, 1'b0);
    chk1({name, "_addr_match"}, bus.addr_match, 1'b0);
    chk1({name, "_busy"}, bus.busy, 1'b0);
    chk8({name, "_rx_count"}, bus.rx_count, 8'd0);
    chk1({name, "_pulses"}, bus.tx_req | bus.overrun | bus.err, 1'b0);
  endtask

  logic [7:0] exp_stream [4];

  initial begin
    checks = 0; errors = 0;
    exp_stream = '{8'h3C, 8'h11, 8'h77, 8'h55};
    rst_n = 1'b0;
    bus.start_det = 1'b0; bus.stop_det = 1'b0;
    bus.byte_read_i = 8'h00; bus.byte_read_finish_i = 1'b0; bus.byte_read_err_i = 1'b0;
    bus.ack_write_finish_i = 1'b0; bus.ack_write_err_i = 1'b0; bus.rx_ready = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // Plain write of 0x3C.
    send_start();
    chk1("start_byte_read_en", bus.byte_read_en, 1'b1);
    rd_byte(8'hA0);
    chk1("wr_byte_read_en_gap", bus.byte_read_en, 1'b0);
    ack_slot("wr_addr", 1'b0);
    chk1("wr_data_read_en", bus.byte_read_en, 1'b1);
    rd_byte(8'h3C);
    chk8("wr_rx_data", bus.rx_data, 8'h3C);
    ack_slot("wr_data", 1'b0);
    send_stop();
    chk8("wr_rx_count", bus.rx_count, 8'd1);
    chk1("wr_idle", bus.busy, 1'b0);

    // Address mismatch: later bytes ignored until STOP.
    send_start();
    rd_byte(8'hA2);
    chk1("mis_no_ack", bus.ack_write_en, 1'b0);
    chk1("mis_match", bus.addr_match, 1'b0);
    chk1("mis_busy", bus.busy, 1'b1);
    rd_byte(8'hA0);
    chk1("mis_ignored_match", bus.addr_match, 1'b0);
    chk1("mis_ignored_ack", bus.ack_write_en, 1'b0);
    send_stop();

    // Read request handed off.
    send_start();
    rd_byte(8'hA1);
    chk1("rd_tx_req", bus.tx_req, 1'b1);
    chk1("rd_match", bus.addr_match, 1'b1);
    tick();
    chk1("rd_tx_req_end", bus.tx_req, 1'b0);
    chk1("rd_no_ack", bus.ack_write_en, 1'b0);
    chk1("rd_no_read", bus.byte_read_en, 1'b0);
    send_stop();
    chk1("rd_match_cleared", bus.addr_match, 1'b0);

    // Overrun with the host stalled.
    bus.rx_ready = 1'b0;
    send_start();
    rd_byte(8'hA0);
    ack_slot("ovr_addr", 1'b0);
    rd_byte(8'h11);
    ack_slot("ovr_d0", 1'b0);
    rd_byte(8'h22);
    chk1("ovr_pulse", bus.overrun, 1'b1);
    ack_slot("ovr_d1", 1'b1);
    chk1("ovr_wait_read", bus.byte_read_en, 1'b0);
    chk1("ovr_wait_busy", bus.busy, 1'b1);
    chk8("ovr_rx_data", bus.rx_data, 8'h11);
    chk8("ovr_rx_count", bus.rx_count, 8'd1);
    send_stop();
    bus.rx_ready = 1'b1;
    tick(); tick();

    // Repeated START during DATA, then STOP colliding with a byte.
    send_start();
    rd_byte(8'hA0);
    ack_slot("rs_addr0", 1'b0);
    rd_byte(8'h77);
    ack_slot("rs_d0", 1'b0);
    chk8("rs_count_before", bus.rx_count, 8'd1);
    send_start();
    chk8("rs_count_cleared", bus.rx_count, 8'd0);
    chk1("rs_match_cleared", bus.addr_match, 1'b0);
    rd_byte(8'hA0);
    ack_slot("rs_addr1", 1'b0);
    rd_byte(8'h55);
    ack_slot("rs_d1", 1'b0);
    chk8("rs_count_after", bus.rx_count, 8'd1);
    tick();
    bus.byte_read_i = 8'h99; bus.byte_read_finish_i = 1'b1; bus.stop_det = 1'b1;
    tick();
    bus.byte_read_finish_i = 1'b0; bus.stop_det = 1'b0;
    chk1("col_idle", bus.busy, 1'b0);
    chk1("col_not_loaded", bus.rx_valid, 1'b0);
    chk8("col_rx_data", bus.rx_data, 8'h55);
    chk8("col_rx_count", bus.rx_count, 8'd1);
    tick();

    // Engine error in DATA.
    send_start();
    rd_byte(8'hA0);
    ack_slot("err_addr", 1'b0);
    tick();
    bus.byte_read_err_i = 1'b1; tick(); bus.byte_read_err_i = 1'b0;
    chk1("err_pulse", bus.err, 1'b1);
    tick();
    chk1("err_pulse_end", bus.err, 1'b0);
    chk1("err_wait_busy", bus.busy, 1'b1);
    chk1("err_wait_read", bus.byte_read_en, 1'b0);
    send_stop();

    // Asynchronous reset in the middle of DATA.
    bus.rx_ready = 1'b0;
    send_start();
    rd_byte(8'hA0);
    ack_slot("rst_addr", 1'b0);
    rd_byte(8'h42);
    ack_slot("rst_d0", 1'b0);
    chk1("rst_pre_valid", bus.rx_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL host_stream_len: got %0d bytes expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) chk8("host_stream", got[i], exp_stream[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
